// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop synchronizers, per-button debounce FSMs with press pulses,
// and a single-entry command register with valid/ack handshake. Define AUTO_REPEAT_EN for held-button auto-repeat.
module button_conditioner #(
    parameter int NUM_BTN       = 5,
    parameter int DEBOUNCE_BITS = 17,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic [7:0]         sw_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic               cmd_valid,
    output logic [NUM_BTN-1:0] cmd_btn,
    output logic [7:0]         cmd_sw,
    input  logic               cmd_ack,
    output logic               overrun
);

    typedef enum logic [1:0] {
        LOW,
        RISE,
        HIGH,
        FALL
    } btn_state_e;

    localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX = '1;

    logic [NUM_BTN-1:0] btn_meta_q;
    logic [NUM_BTN-1:0] btn_sync_q;
    logic [7:0]         sw_meta_q;
    logic [7:0]         sw_sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            btn_meta_q <= btn_in;
            btn_sync_q <= btn_meta_q;
            sw_meta_q  <= sw_in;
            sw_sync_q  <= sw_meta_q;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [31:0] RPT_FIRST = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RPT_NEXT  = 32'(REPEAT_PERIOD - 1);
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_state_e               state_q;
        logic [DEBOUNCE_BITS-1:0] cnt_q;
        logic                     level_q;
        logic                     press_q;
`ifdef AUTO_REPEAT_EN
        logic [31:0]              rpt_cnt_q;
        logic                     rpt_first_q;
`endif

        // A level change is accepted only after the synchronized input has held the new value for the full counter span.
        always_ff @(posedge clock) begin
            if (reset) begin
                state_q     <= LOW;
                cnt_q       <= '0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
`ifdef AUTO_REPEAT_EN
                rpt_cnt_q   <= '0;
                rpt_first_q <= 1'b1;
`endif
            end else begin
                press_q <= 1'b0;
                case (state_q)
                    LOW: begin
                        if (btn_sync_q[i]) begin
                            state_q <= RISE;
                            cnt_q   <= '0;
                        end
                    end
                    RISE: begin
                        if (!btn_sync_q[i]) begin
                            state_q <= LOW;
                        end else if (cnt_q == CNT_MAX) begin
                            state_q     <= HIGH;
                            level_q     <= 1'b1;
                            press_q     <= 1'b1;
`ifdef AUTO_REPEAT_EN
                            rpt_cnt_q   <= '0;
                            rpt_first_q <= 1'b1;
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    HIGH: begin
                        if (!btn_sync_q[i]) begin
                            state_q <= FALL;
                            cnt_q   <= '0;
                        end
`ifdef AUTO_REPEAT_EN
                        else if (rpt_cnt_q == (rpt_first_q ? RPT_FIRST : RPT_NEXT)) begin
                            press_q     <= 1'b1;
                            rpt_cnt_q   <= '0;
                            rpt_first_q <= 1'b0;
                        end else begin
                            rpt_cnt_q <= rpt_cnt_q + 32'd1;
                        end
`endif
                    end
                    FALL: begin
                        if (btn_sync_q[i]) begin
                            state_q     <= HIGH;
`ifdef AUTO_REPEAT_EN
                            rpt_cnt_q   <= '0;
                            rpt_first_q <= 1'b1;
`endif
                        end else if (cnt_q == CNT_MAX) begin
                            state_q <= LOW;
                            level_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= LOW;
                    end
                endcase
            end
        end

        assign btn_level[i] = level_q;
        assign btn_press[i] = press_q;
    end

    logic               cmd_valid_q, cmd_valid_d;
    logic [NUM_BTN-1:0] cmd_btn_q, cmd_btn_d;
    logic [7:0]         cmd_sw_q, cmd_sw_d;
    logic               overrun_q, overrun_d;
    logic [NUM_BTN-1:0] first_press;

    // Isolates the lowest set bit, which is the highest-priority button.
    assign first_press = btn_press & (-btn_press);

    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_btn_d   = cmd_btn_q;
        cmd_sw_d    = cmd_sw_q;
        overrun_d   = overrun_q;
        if (|btn_press) begin
            if (!cmd_valid_q || cmd_ack) begin
                cmd_valid_d = 1'b1;
                cmd_btn_d   = first_press;
                cmd_sw_d    = sw_sync_q;
                if ((btn_press & ~first_press) != '0) begin
                    overrun_d = 1'b1;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end else if (cmd_ack) begin
            cmd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_valid_q <= 1'b0;
            cmd_btn_q   <= '0;
            cmd_sw_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            cmd_valid_q <= cmd_valid_d;
            cmd_btn_q   <= cmd_btn_d;
            cmd_sw_q    <= cmd_sw_d;
            overrun_q   <= overrun_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_btn   = cmd_btn_q;
    assign cmd_sw    = cmd_sw_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a stability-run reference model predicts press pulses,
// level changes and command-register updates; a negedge monitor pops and compares them.
module tb_button_conditioner;

    localparam int NB     = 5;
    localparam int DB     = 2;
    localparam int RD     = 10;
    localparam int RP     = 4;
    localparam int STABLE = (1 << DB) + 1;
`ifdef AUTO_REPEAT_EN
    localparam bit AUTO_REPEAT = 1'b1;
`else
    localparam bit AUTO_REPEAT = 1'b0;
`endif

    logic          clock   = 1'b0;
    logic          reset   = 1'b1;
    logic [NB-1:0] btn_in  = '0;
    logic [7:0]    sw_in   = '0;
    logic          cmd_ack = 1'b0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic          cmd_valid;
    logic [NB-1:0] cmd_btn;
    logic [7:0]    cmd_sw;
    logic          overrun;

    typedef struct {
        longint      cyc;
        logic [14:0] val;
    } event_t;

    event_t pressQ[$];
    event_t levelQ[$];
    event_t cmdQ[$];
    int     checks  = 0;
    int     passes  = 0;
    longint edgeCnt = 0;

    button_conditioner #(
        .NUM_BTN(NB),
        .DEBOUNCE_BITS(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .btn_in(btn_in),
        .sw_in(sw_in),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .cmd_valid(cmd_valid),
        .cmd_btn(cmd_btn),
        .cmd_sw(cmd_sw),
        .cmd_ack(cmd_ack),
        .overrun(overrun)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edgeCnt);
    endtask

    task automatic applyStimulus(input logic [NB-1:0] btn, input logic [7:0] sw, input logic ack, input int cycles);
        btn_in  = btn;
        sw_in   = sw;
        cmd_ack = ack;
        repeat (cycles) @(negedge clock);
    endtask

    // Reference model: a level flips once the synchronized input has differed from it for STABLE consecutive samples.
    initial begin : model
        logic [NB-1:0] d1, d2, syncB, expLevel, pressPrev, newPress, expBtn, lastLevel;
        logic [7:0]    swD1, swD2, swNow, expSw;
        logic          expValid, expOvr;
        logic [14:0]   cmdPack, lastCmd;
        int            run[NB], held[NB], nextRep[NB];
        int            low;
        d1 = '0; d2 = '0; expLevel = '0; pressPrev = '0; expBtn = '0; lastLevel = '0;
        swD1 = '0; swD2 = '0; expSw = '0; expValid = 1'b0; expOvr = 1'b0; lastCmd = '0;
        for (int i = 0; i < NB; i++) begin
            run[i] = 0; held[i] = 0; nextRep[i] = RD;
        end
        forever begin
            @(posedge clock);
            edgeCnt++;
            newPress = '0;
            if (reset) begin
                d1 = '0; d2 = '0; swD1 = '0; swD2 = '0;
                expLevel = '0; expBtn = '0; expSw = '0; expValid = 1'b0; expOvr = 1'b0;
                for (int i = 0; i < NB; i++) begin
                    run[i] = 0; held[i] = 0; nextRep[i] = RD;
                end
            end else begin
                syncB = d2; d2 = d1; d1 = btn_in;
                swNow = swD2; swD2 = swD1; swD1 = sw_in;
                if (|pressPrev) begin
                    if (!expValid || cmd_ack) begin
                        low = 0;
                        for (int i = NB - 1; i >= 0; i--) if (pressPrev[i]) low = i;
                        expBtn = '0;
                        expBtn[low] = 1'b1;
                        expSw = swNow;
                        expValid = 1'b1;
                        if ((pressPrev & ~expBtn) != '0) expOvr = 1'b1;
                    end else begin
                        expOvr = 1'b1;
                    end
                end else if (cmd_ack) begin
                    expValid = 1'b0;
                end
                for (int i = 0; i < NB; i++) begin
                    if (syncB[i] != expLevel[i]) begin
                        run[i]++;
                        if (run[i] == STABLE) begin
                            expLevel[i] = syncB[i];
                            run[i] = 0;
                            if (syncB[i]) begin
                                newPress[i] = 1'b1; held[i] = 0; nextRep[i] = RD;
                            end
                        end
                    end else begin
                        if (expLevel[i] && run[i] != 0) begin
                            held[i] = 0; nextRep[i] = RD;
                        end else if (expLevel[i] && AUTO_REPEAT) begin
                            held[i]++;
                            if (held[i] == nextRep[i]) begin
                                newPress[i] = 1'b1; held[i] = 0; nextRep[i] = RP;
                            end
                        end
                        run[i] = 0;
                    end
                end
            end
            pressPrev = newPress;
            if (newPress != '0) pressQ.push_back('{edgeCnt, 15'(newPress)});
            if (expLevel != lastLevel) begin
                levelQ.push_back('{edgeCnt, 15'(expLevel)});
                lastLevel = expLevel;
            end
            cmdPack = {expValid, expBtn, expSw, expOvr};
            if (cmdPack != lastCmd) begin
                cmdQ.push_back('{edgeCnt, cmdPack});
                lastCmd = cmdPack;
            end
        end
    end

    // Monitor: whenever the DUT shows a pulse or an output change, pop the oldest prediction and compare.
    initial begin : monitor
        logic [NB-1:0] prevLevel;
        logic [14:0]   prevCmd, cmdNow;
        event_t        ev;
        prevLevel = '0;
        prevCmd   = '0;
        forever begin
            @(negedge clock);
            if (btn_press !== '0) begin
                if (pressQ.size() == 0) checkOutput("press unexpected", 64'(btn_press), 64'd0);
                else begin
                    ev = pressQ.pop_front();
                    checkOutput("press value", 64'(btn_press), 64'(ev.val));
                    checkOutput("press edge", 64'(edgeCnt), 64'(ev.cyc));
                end
            end
            if (btn_level !== prevLevel) begin
                if (levelQ.size() == 0) checkOutput("level unexpected", 64'(btn_level), 64'(prevLevel));
                else begin
                    ev = levelQ.pop_front();
                    checkOutput("level value", 64'(btn_level), 64'(ev.val));
                    checkOutput("level edge", 64'(edgeCnt), 64'(ev.cyc));
                end
                prevLevel = btn_level;
            end
            cmdNow = {cmd_valid, cmd_btn, cmd_sw, overrun};
            if (cmdNow !== prevCmd) begin
                if (cmdQ.size() == 0) checkOutput("cmd unexpected", 64'(cmdNow), 64'(prevCmd));
                else begin
                    ev = cmdQ.pop_front();
                    checkOutput("cmd value", 64'(cmdNow), 64'(ev.val));
                    checkOutput("cmd edge", 64'(edgeCnt), 64'(ev.cyc));
                end
                prevCmd = cmdNow;
            end
        end
    end

    initial begin : stimulus
        logic [NB-1:0] rndBtn;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checkOutput("reset outputs", 64'({btn_level, btn_press, cmd_valid, cmd_btn, cmd_sw, overrun}), 64'd0);

        applyStimulus(5'b00000, 8'h00, 1'b0, 20);
        checkOutput("idle outputs", 64'({btn_level, btn_press, cmd_valid, cmd_btn, cmd_sw, overrun}), 64'd0);

        applyStimulus(5'b00100, 8'hA5, 1'b0, 9);
        checkOutput("btn2 cmd_valid", 64'(cmd_valid), 64'd1);
        checkOutput("btn2 cmd_btn", 64'(cmd_btn), 64'h04);
        checkOutput("btn2 cmd_sw", 64'(cmd_sw), 64'hA5);
        checkOutput("btn2 level", 64'(btn_level), 64'h04);
        applyStimulus(5'b00100, 8'hA5, 1'b1, 1);
        applyStimulus(5'b00000, 8'hA5, 1'b0, 1);
        checkOutput("ack clears valid", 64'(cmd_valid), 64'd0);
        applyStimulus(5'b00000, 8'hA5, 1'b0, 10);

        for (int k = 0; k < 10; k++) begin
            applyStimulus(5'b00010, 8'h11, 1'b0, 2);
            applyStimulus(5'b00000, 8'h11, 1'b0, 2);
        end
        applyStimulus(5'b00000, 8'h11, 1'b0, 8);
        checkOutput("glitch level", 64'(btn_level), 64'd0);

        applyStimulus(5'b01001, 8'h3C, 1'b0, 9);
        checkOutput("dual cmd_btn", 64'(cmd_btn), 64'h01);
        checkOutput("dual overrun", 64'(overrun), 64'd1);
        applyStimulus(5'b00000, 8'h3C, 1'b0, 10);
        applyStimulus(5'b10000, 8'h77, 1'b0, 9);
        checkOutput("busy cmd_btn", 64'(cmd_btn), 64'h01);
        checkOutput("busy cmd_sw", 64'(cmd_sw), 64'h3C);
        checkOutput("busy overrun", 64'(overrun), 64'd1);
        applyStimulus(5'b00000, 8'h77, 1'b0, 10);

        reset = 1'b1;
        applyStimulus(5'b00000, 8'h00, 1'b0, 2);
        reset = 1'b0;
        applyStimulus(5'b00001, 8'h12, 1'b0, 9);
        applyStimulus(5'b00000, 8'h12, 1'b0, 10);
        applyStimulus(5'b01000, 8'h5A, 1'b0, 7);
        applyStimulus(5'b01000, 8'h5A, 1'b1, 1);
        applyStimulus(5'b00000, 8'h5A, 1'b0, 1);
        checkOutput("ack+press valid", 64'(cmd_valid), 64'd1);
        checkOutput("ack+press cmd_btn", 64'(cmd_btn), 64'h08);
        checkOutput("ack+press overrun", 64'(overrun), 64'd0);
        applyStimulus(5'b00000, 8'h5A, 1'b0, 10);

        applyStimulus(5'b00001, 8'hC3, 1'b0, 40);
        applyStimulus(5'b00000, 8'hC3, 1'b0, 12);

        applyStimulus(5'b00100, 8'h99, 1'b0, 3);
        reset = 1'b1;
        applyStimulus(5'b00000, 8'h99, 1'b0, 1);
        reset = 1'b0;
        applyStimulus(5'b00000, 8'h99, 1'b0, 10);
        checkOutput("mid-press reset", 64'({btn_level, btn_press, cmd_valid, cmd_btn, cmd_sw, overrun}), 64'd0);

        rndBtn = '0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 5) == 0) rndBtn[$urandom_range(0, NB - 1)] ^= 1'b1;
            applyStimulus(rndBtn, 8'($urandom), 1'($urandom_range(0, 3) == 0), 1);
        end
        applyStimulus(5'b00000, 8'h00, 1'b1, 20);

        checkOutput("press queue drained", 64'(pressQ.size()), 64'd0);
        checkOutput("level queue drained", 64'(levelQ.size()), 64'd0);
        checkOutput("cmd queue drained", 64'(cmdQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
